sseg_scan_driver: RTL and testbench

Time-multiplexed scan driver for the board's 16-digit seven-segment display (8 segment lines including the decimal point, 16 digit commons). It takes segment patterns from an upstream writer, such as a UART command decoder or a gauge formatter, into a shadow frame buffer. It commits them atomically at frame boundaries so a partial update never reaches the display, then scans the active frame onto C_SSEG/C with anti-ghosting blanking and a daylight/dim duty control. It replaces the free-running test pattern that currently drives those pins.

---
 rtl/blastit_display_pkg.sv | 15 +
 rtl/sseg_frame_buffer.sv | 32 +++
 rtl/sseg_scan_driver.sv | 85 ++++++++
 tb/tb_sseg_scan_driver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/blastit_display_pkg.sv
// blastit_display_pkg: shared display geometry and hex-to-segment table
package blastit_display_pkg;
  localparam int NUM_DIGITS = 16;
  localparam int SEG_BITS = 8;
  localparam int DP_BIT = 7;
  localparam int DIGIT_BITS = $clog2(NUM_DIGITS);
  // gfedcba patterns for 0..F, index 15 first
  localparam logic [15:0][SEG_BITS-1:0] HEX_SEG = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };
  function automatic logic [SEG_BITS-1:0] hex_to_seg(input logic [3:0] h, input logic dp);
    return HEX_SEG[h] | (SEG_BITS'(dp) << DP_BIT);
  endfunction
endpackage

// File: rtl/sseg_frame_buffer.sv
// sseg_frame_buffer: shadow/active segment storage with atomic shadow-to-active copy
module sseg_frame_buffer
  import blastit_display_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DIGIT_BITS-1:0] wr_addr,
  input  logic [SEG_BITS-1:0]   wr_data,
  input  logic                  commit,
  input  logic [DIGIT_BITS-1:0] rd_addr,
  output logic [SEG_BITS-1:0]   rd_data
);
  logic [NUM_DIGITS-1:0][SEG_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
  // writes land in shadow only; a commit copies the pre-write shadow image
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;
    active_d = commit ? shadow_q : active_q;
    rd_data = active_q[rd_addr];
  end
  // storage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 16-digit multiplexed seven-segment scan with blanking, dimming and frame-atomic commits
module sseg_scan_driver
  import blastit_display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 5000,
  parameter int BLANK_CYCLES = 250,
  parameter int CNT_BITS     = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DIGIT_BITS-1:0] wr_addr,
  input  logic [SEG_BITS-1:0]   wr_data,
  input  logic                  commit_req,
  input  logic                  dim,
  output logic [SEG_BITS-1:0]   c_sseg,
  output logic [NUM_DIGITS-1:0] c,
  output logic                  frame_start,
  output logic                  commit_pending
);
  localparam logic [CNT_BITS-1:0] SLOT_LAST = CNT_BITS'(SLOT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] BLANK_END = CNT_BITS'(BLANK_CYCLES);
  localparam logic [CNT_BITS-1:0] DIM_END = CNT_BITS'(BLANK_CYCLES + (SLOT_CYCLES - BLANK_CYCLES) / 4);
  localparam logic [DIGIT_BITS-1:0] DIGIT_LAST = DIGIT_BITS'(NUM_DIGITS - 1);
  logic [CNT_BITS-1:0]   slot_cnt_q, slot_cnt_d;
  logic [DIGIT_BITS-1:0] digit_q, digit_d;
  logic                  pending_q, pending_d;
  logic [SEG_BITS-1:0]   seg_q, seg_d, rd_data;
  logic [NUM_DIGITS-1:0] c_q, c_d;
  logic                  frame_start_q, frame_start_d;
  logic                  commit_pending_q, commit_pending_d;
  logic                  slot_end, boundary, commit, lit;
  sseg_frame_buffer u_fb (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .commit  (commit),
    .rd_addr (digit_q),
    .rd_data (rd_data)
  );
  // scan counters, commit queueing and next pin values from the current state
  always_comb begin
    slot_end = slot_cnt_q == SLOT_LAST;
    boundary = slot_end && digit_q == DIGIT_LAST;
    commit = boundary && pending_q;
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + CNT_BITS'(1);
    digit_d = slot_end ? digit_q + DIGIT_BITS'(1) : digit_q;
    pending_d = commit_req || (pending_q && !boundary);
    lit = slot_cnt_q >= BLANK_END && (!dim || slot_cnt_q < DIM_END);
    seg_d = lit ? rd_data : '0;
    c_d = NUM_DIGITS'(1) << digit_q;
    frame_start_d = slot_cnt_q == '0 && digit_q == '0;
    commit_pending_d = pending_q;
  end
  // state and registered pin enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_q <= '0;
      digit_q <= '0;
      pending_q <= 1'b0;
      seg_q <= '0;
      c_q <= '0;
      frame_start_q <= 1'b0;
      commit_pending_q <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q <= digit_d;
      pending_q <= pending_d;
      seg_q <= seg_d;
      c_q <= c_d;
      frame_start_q <= frame_start_d;
      commit_pending_q <= commit_pending_d;
    end
  end
  for (genvar i = 0; i < SEG_BITS; i++) begin : g_seg
    assign c_sseg[i] = seg_q[i] ? 1'b0 : 1'bz;
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign c[i] = c_q[i] ? 1'b1 : 1'bz;
  end
  assign frame_start = frame_start_q;
  assign commit_pending = commit_pending_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: scoreboard plus vector table for the scan driver (SLOT=8, BLANK=2)
module tb_sseg_scan_driver;
  logic clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, commit_req = 1'b0, dim = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  wire [7:0] c_sseg;
  wire [15:0] c;
  wire frame_start, commit_pending;
  // released segment sinks read high, released digit sources read low
  pullup (c_sseg);
  pulldown (c);
  always #5 clk = ~clk;
  sseg_scan_driver #(.SLOT_CYCLES(8), .BLANK_CYCLES(2), .CNT_BITS(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit_req     (commit_req),
    .dim            (dim),
    .c_sseg         (c_sseg),
    .c              (c),
    .frame_start    (frame_start),
    .commit_pending (commit_pending)
  );
  typedef struct packed {logic [15:0] c; logic [7:0] seg; logic fs; logic cp;} out_t;
  typedef struct packed {logic d; logic [2:0] slot; logic [7:0] seg;} vec_t;
  out_t sb[$];
  out_t exp_o;
  vec_t vt[11];
  logic [6:0] m_pos;
  logic m_pend;
  logic [15:0][7:0] m_sh, m_act;
  int n_tot = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_pos(input logic [6:0] p);
    for (int k = 0; k < 300 && m_pos != p; k++) tick();
    if (m_pos != p) begin
      n_tot++;
      $display("FAIL wait_pos: got %0d want %0d", m_pos, p);
    end
  endtask
  // behavioural model: frame position 0..127, expected pins pushed at each edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos <= '0;
      m_pend <= 1'b0;
      m_sh <= '0;
      m_act <= '0;
      sb.delete();
    end else begin
      sb.push_back('{c: 16'(1) << m_pos[6:3],
                     seg: ~((m_pos[2:0] >= 3'd2 && (!dim || m_pos[2:0] < 3'd3)) ? m_act[m_pos[6:3]] : 8'h00),
                     fs: m_pos == 7'd0, cp: m_pend});
      m_pos <= m_pos + 7'd1;
      if (m_pos == 7'd127 && m_pend) m_act <= m_sh;
      m_pend <= commit_req || (m_pend && m_pos != 7'd127);
      if (wr_en) m_sh[wr_addr] <= wr_data;
    end
  end
  // scoreboard compare away from the active edge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_o = sb.pop_front();
      chk("scan", {6'b0, c, c_sseg, frame_start, commit_pending}, {6'b0, exp_o});
    end
  end
  initial begin
    int k;
    logic seen;
    vt = '{'{1'b0, 3'd0, 8'hFF}, '{1'b0, 3'd1, 8'hFF}, '{1'b0, 3'd2, 8'h79}, '{1'b0, 3'd5, 8'h79},
           '{1'b0, 3'd7, 8'h79}, '{1'b1, 3'd1, 8'hFF}, '{1'b1, 3'd2, 8'h79}, '{1'b1, 3'd3, 8'hFF},
           '{1'b0, 3'd4, 8'h79}, '{1'b1, 3'd6, 8'hFF}, '{1'b0, 3'd7, 8'h79}};
    repeat (3) tick();
    chk("rst_seg", c_sseg, 8'hFF);
    chk("rst_c", c, 16'h0000);
    chk("rst_fs", frame_start, 0);
    chk("rst_cp", commit_pending, 0);
    reset_n = 1'b1;
    tick();
    chk("first_c", c, 16'h0001);
    chk("first_fs", frame_start, 1);
    chk("first_seg", c_sseg, 8'hFF);
    for (int i = 1; i < 16; i++) begin
      repeat (8) tick();
      chk("step_c", c, 16'(1) << i);
    end
    k = 0;
    do begin tick(); k++; end while (frame_start !== 1'b1 && k < 300);
    k = 0;
    do begin tick(); k++; end while (frame_start !== 1'b1 && k < 300);
    chk("fs_period", k, 128);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h86;
    tick();
    wr_en = 1'b0;
    seen = 1'b0;
    repeat (3 * 128) begin
      tick();
      if (c_sseg !== 8'hFF || commit_pending !== 1'b0) seen = 1'b1;
    end
    chk("no_commit", seen, 0);
    wait_pos(7'd40);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    chk("cp_rise", commit_pending, 1);
    wait_pos(7'd127);
    tick();
    chk("cp_hold", commit_pending, 1);
    tick();
    chk("pub_fs", frame_start, 1);
    chk("cp_fall", commit_pending, 0);
    for (int i = 0; i < 11; i++) begin
      wait_pos({4'd3, vt[i].slot});
      dim = vt[i].d;
      tick();
      chk("win_c", c, 16'h0008);
      chk("win_seg", c_sseg, vt[i].seg);
    end
    dim = 1'b0;
    wait_pos(7'd127);
    commit_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h3F;
    tick();
    commit_req = 1'b0; wr_en = 1'b0;
    wait_pos(7'd28);
    tick();
    chk("old_frame", c_sseg, 8'h79);
    chk("cp_queued", commit_pending, 1);
    wait_pos(7'd28);
    tick();
    chk("new_frame", c_sseg, 8'hC0);
    chk("cp_done", commit_pending, 0);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wait_pos(7'd75);
    reset_n = 1'b0;
    #1;
    chk("arst_seg", c_sseg, 8'hFF);
    chk("arst_c", c, 16'h0000);
    chk("arst_cp", commit_pending, 0);
    chk("arst_fs", frame_start, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("restart_c", c, 16'h0001);
    chk("restart_fs", frame_start, 1);
    wait_pos(7'd28);
    tick();
    chk("cleared_active", c_sseg, 8'hFF);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wait_pos(7'd28);
    tick();
    chk("cleared_shadow", c_sseg, 8'hFF);
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
